mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder_pkg.sv | 32 +++
 rtl/mem_fill_responder_fill_word_ctr.sv | 44 ++++
 rtl/mem_fill_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_fill_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_responder_pkg.sv
// mem_fill_pkg
// Shared types and constants for the memory fill responder.
//   state_t      : responder FSM states (IDLE, FILL, WRITE)
//   BLOCK_WORDS  : 16-bit words per cache block
//   MEM_LATENCY  : cycles from read issue to mem_rvalid
//   WORD_IDX_W   : width of a word index inside a block
//   last_word()  : index of the final word of a wrapping 8-word burst
//   word_addr()  : byte address of a word inside a block
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned BLOCK_WORDS = 32'd8;
  localparam int unsigned MEM_LATENCY = 32'd4;
  localparam int unsigned WORD_IDX_W  = 32'd3;

  // Last index of a burst that starts at 'first' and wraps modulo the block size.
  function automatic logic [WORD_IDX_W-1:0] last_word(input logic [WORD_IDX_W-1:0] first);
    return first + WORD_IDX_W'(BLOCK_WORDS - 32'd1);
  endfunction

  // Words are 16 bits, so bit 0 of the byte address is always zero.
  function automatic logic [15:0] word_addr(input logic [11:0]            base_hi,
                                            input logic [WORD_IDX_W-1:0] idx);
    return {base_hi, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mem_fill_responder_fill_word_ctr.sv
// fill_word_ctr
// Wrapping word-index counter used for both the read-issue and the
// read-return side of a block fill.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : start a new burst at load_val
//   load_val  : first word index of the burst
//   inc       : advance to the next word (wraps 7 -> 0)
//   cnt       : current word index
//   tc        : current word is the last word of the burst
module fill_word_ctr
  import mem_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_IDX_W-1:0] load_val,
  input  logic                  inc,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  tc
);

  logic [WORD_IDX_W-1:0] cnt_r;
  logic [WORD_IDX_W-1:0] last_r;

  // Counter and burst-end registers; the end index is fixed when the burst is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {WORD_IDX_W{1'b0}};
      last_r <= {WORD_IDX_W{1'b0}};
    end else if (load) begin
      cnt_r  <= load_val;
      last_r <= last_word(load_val);
    end else if (inc) begin
      cnt_r  <= cnt_r + WORD_IDX_W'(1'b1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == last_r);

endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder
// Serves I-cache and D-cache misses from a fixed-latency memory. A D-cache
// store is written through in a single WRITE cycle; a fill reads the 8 words
// of the 16-byte block on consecutive cycles and forwards each return.
// D-cache requests win ties in IDLE; a grant is held until its done pulse.
// Build option: FILL_CRIT_WORD_FIRST_EN -- start a fill at the missed word
// (addr[3:1]) and wrap, instead of starting at word 0.
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   ic_req, ic_addr                    : I-cache miss request / byte address
//   dc_req, dc_addr, dc_wr, dc_wdata   : D-cache request, address, store flag, store data
//   fill_valid, fill_data, fill_word,
//   fill_to_dc                         : returned fill word, its index and target cache
//   ic_done, dc_done                   : one-cycle completion pulses
//   busy                               : FSM not IDLE
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                          : memory command
//   mem_rdata, mem_rvalid              : memory read return (4 cycles after issue)
module mem_fill_responder
  import mem_fill_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic [15:0] dc_addr,
  input  logic        dc_wr,
  input  logic [15:0] dc_wdata,
  output logic        fill_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        fill_to_dc,
  output logic        ic_done,
  output logic        dc_done,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  state_t                state;
  logic [11:0]           base_hi;
  logic                  to_dc;
  logic                  issuing;
  logic [15:0]           wr_addr;
  logic [15:0]           wr_data;
  logic                  start_fill;
  logic [WORD_IDX_W-1:0] start_idx;
  logic [WORD_IDX_W-1:0] issue_cnt;
  logic [WORD_IDX_W-1:0] ret_cnt;
  logic                  issue_tc;
  logic                  ret_tc;
  logic                  issue_inc;
  logic                  fill_last;
  logic                  unused_addr_bits;

  // Only fills load the counters; a store never touches them.
  assign start_fill = (state == IDLE) && ((dc_req && !dc_wr) || (ic_req && !dc_req));
  assign issue_inc  = (state == FILL) && issuing;

  // The word offset bits only matter when the fill starts at the missed word.
  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0]};

  // First word index of a new fill (the D-cache address wins on a tie).
  always_comb begin
`ifdef FILL_CRIT_WORD_FIRST_EN
    start_idx = dc_req ? dc_addr[3:1] : ic_addr[3:1];
`else
    start_idx = {WORD_IDX_W{1'b0}};
`endif
  end

  fill_word_ctr u_issue_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_fill),
    .load_val (start_idx),
    .inc      (issue_inc),
    .cnt      (issue_cnt),
    .tc       (issue_tc)
  );

  // Returns come back in issue order, so the return counter replays the same sequence.
  fill_word_ctr u_ret_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_fill),
    .load_val (start_idx),
    .inc      (fill_valid),
    .cnt      (ret_cnt),
    .tc       (ret_tc)
  );

  // Responder FSM: grant arbitration, per-transaction latches, completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_hi <= 12'h000;
      to_dc   <= 1'b0;
      issuing <= 1'b0;
      wr_addr <= 16'h0000;
      wr_data <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (dc_req && dc_wr) begin
            state   <= WRITE;
            wr_addr <= dc_addr;
            wr_data <= dc_wdata;
          end else if (dc_req) begin
            state   <= FILL;
            base_hi <= dc_addr[15:4];
            to_dc   <= 1'b1;
            issuing <= 1'b1;
          end else if (ic_req) begin
            state   <= FILL;
            base_hi <= ic_addr[15:4];
            to_dc   <= 1'b0;
            issuing <= 1'b1;
          end else begin
            state   <= IDLE;
          end
        end
        FILL: begin
          // Issue side stops after the 8th read; returns keep arriving.
          if (issuing && issue_tc) begin
            issuing <= 1'b0;
          end else begin
            issuing <= issuing;
          end
          if (fill_last) begin
            state <= IDLE;
          end else begin
            state <= FILL;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory command decode from the registered FSM state.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state)
      FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(base_hi, issue_cnt);
        end else begin
          mem_en   = 1'b0;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Returns are forwarded in the cycle they arrive; anything outside FILL is dropped.
  assign fill_valid = (state == FILL) && mem_rvalid;
  assign fill_last  = fill_valid && ret_tc;
  assign fill_data  = fill_valid ? mem_rdata : 16'h0000;
  assign fill_word  = fill_valid ? ret_cnt : {WORD_IDX_W{1'b0}};
  assign fill_to_dc = (state == FILL) && to_dc;
  assign ic_done    = fill_last && !to_dc;
  assign dc_done    = (state == WRITE) || (fill_last && to_dc);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder
// Directed plus randomized bench for mem_fill_responder. A behavioural memory
// (fixed 4-cycle read latency, write-through storage) sits on the memory
// port. Expected fill traffic is computed from block/word arithmetic and a
// reference copy of every store the bench issued.
// Build option: FILL_CRIT_WORD_FIRST_EN (must match the RTL build).
module tb_mem_fill_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic        dc_req;
  logic [15:0] dc_addr;
  logic        dc_wr;
  logic [15:0] dc_wdata;
  logic        fill_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_to_dc;
  logic        ic_done;
  logic        dc_done;
  logic        busy;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  mem_fill_responder dut (
    .clk        (clk),
    .rst        (rst),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .dc_req     (dc_req),
    .dc_addr    (dc_addr),
    .dc_wr      (dc_wr),
    .dc_wdata   (dc_wdata),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_word  (fill_word),
    .fill_to_dc (fill_to_dc),
    .ic_done    (ic_done),
    .dc_done    (dc_done),
    .busy       (busy),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [15:0] seed;
  logic [15:0] env_mem [0:32767];
  bit          env_wv  [0:32767];
  logic [3:0]  rv_pipe = 4'b0000;
  logic [15:0] rd_pipe [0:3];
  logic        inject_rv;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ seed;
  endfunction

  function automatic logic [15:0] env_read(input logic [15:0] a);
    return env_wv[a[15:1]] ? env_mem[a[15:1]] : init_word(a);
  endfunction

  // Fixed-latency read pipeline and write-through storage.
  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[2:0], mem_en & ~mem_wr};
    rd_pipe[0] <= env_read(mem_addr);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
    rd_pipe[3] <= rd_pipe[2];
    if (mem_en && mem_wr) begin
      env_mem[mem_addr[15:1]] <= mem_wdata;
      env_wv[mem_addr[15:1]]  <= 1'b1;
    end
  end

  assign mem_rvalid = rv_pipe[3] | inject_rv;
  assign mem_rdata  = rv_pipe[3] ? rd_pipe[3] : 16'h0BAD;

  // ---------------- reference model ----------------
  logic [15:0] ref_wr [logic [14:0]];

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return ref_wr.exists(a[15:1]) ? ref_wr[a[15:1]] : init_word(a);
  endfunction

  function automatic logic [2:0] first_word(input logic [15:0] a);
`ifdef FILL_CRIT_WORD_FIRST_EN
    return a[3:1];
`else
    return 3'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Watch one fill from the current negedge; first issue expected on sample exp_first.
  task automatic observe_fill(input bit is_dc, input logic [15:0] addr,
                              input int exp_first, input string tag);
    int          t;
    int          t0;
    int          n_iss;
    int          n_ret;
    bit          done_seen;
    logic [2:0]  w;
    logic [15:0] a;
    t = 0; t0 = -1; n_iss = 0; n_ret = 0; done_seen = 1'b0;
    while (!done_seen && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_en) begin
        if (t0 < 0) begin
          t0 = t;
          check({tag, "_grant_cycle"}, t0, exp_first);
        end
        w = first_word(addr) + 3'(n_iss);
        check({tag, "_iss_wr"}, mem_wr, 1'b0);
        check({tag, "_iss_addr"}, mem_addr, {addr[15:4], w, 1'b0});
        check({tag, "_iss_cycle"}, t - t0, n_iss);
        n_iss++;
      end
      if (fill_valid) begin
        w = first_word(addr) + 3'(n_ret);
        a = {addr[15:4], w, 1'b0};
        check({tag, "_word"}, fill_word, w);
        check({tag, "_data"}, fill_data, ref_word(a));
        check({tag, "_to_dc"}, fill_to_dc, is_dc);
        check({tag, "_ret_cycle"}, t - t0, LAT + n_ret);
        n_ret++;
      end
      if (ic_done || dc_done) begin
        done_seen = 1'b1;
        check({tag, "_ic_done"}, ic_done, !is_dc);
        check({tag, "_dc_done"}, dc_done, is_dc);
        check({tag, "_done_cycle"}, t - t0, LAT + WORDS - 1);
        check({tag, "_n_issue"}, n_iss, WORDS);
        check({tag, "_n_return"}, n_ret, WORDS);
        if (is_dc) dc_req = 1'b0;
        else       ic_req = 1'b0;
      end
    end
    check({tag, "_done_seen"}, done_seen, 1'b1);
  endtask

  task automatic do_fill(input bit is_dc, input logic [15:0] addr, input string tag);
    if (is_dc) begin
      dc_req = 1'b1; dc_wr = 1'b0; dc_addr = addr;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    observe_fill(is_dc, addr, 1, tag);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    dc_req = 1'b1; dc_wr = 1'b1; dc_addr = addr; dc_wdata = data;
    @(negedge clk);
    check("wr_en", mem_en, 1'b1);
    check("wr_wr", mem_wr, 1'b1);
    check("wr_addr", mem_addr, addr);
    check("wr_data", mem_wdata, data);
    check("wr_dc_done", dc_done, 1'b1);
    check("wr_ic_done", ic_done, 1'b0);
    check("wr_busy", busy, 1'b1);
    dc_req = 1'b0; dc_wr = 1'b0;
    ref_wr[addr[15:1]] = data;
    @(negedge clk);
    check("wr_after_en", mem_en, 1'b0);
    check("wr_after_done", dc_done, 1'b0);
    check("wr_after_busy", busy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          seen;
    int          t;
    int          rv;
    logic [15:0] ia;
    logic [15:0] da;
    seed      = 16'($urandom);
    rst       = 1'b1;
    ic_req    = 1'b0; ic_addr  = 16'h0000;
    dc_req    = 1'b0; dc_addr  = 16'h0000;
    dc_wr     = 1'b0; dc_wdata = 16'h0000;
    inject_rv = 1'b0;

    // Reset state
    idle(3);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_data", fill_data, 16'h0000);
    check("rst_fill_word", fill_word, 3'd0);
    check("rst_done", {ic_done, dc_done}, 2'b00);
    rst = 1'b0;
    idle(1);

    // I-cache fill of block 0x1230
    do_fill(1'b0, 16'h1236, "ic1236");
    idle(1);

    // D-cache write-through store
    do_write(16'h0040, 16'hBEEF);
    idle(1);

    // Simultaneous requests: D-cache first, I-cache granted after dc_done
    ia = 16'($urandom);
    da = {12'h004, 4'($urandom)};
    ic_req = 1'b1; ic_addr = ia;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = da;
    observe_fill(1'b1, da, 1, "arb_dc");
    observe_fill(1'b0, ia, 2, "arb_ic");
    idle(1);

    // Critical-word address
    do_fill(1'b0, 16'h200C, "ic200c");
    idle(1);

    // Stray mem_rvalid in IDLE
    inject_rv = 1'b1;
    repeat (3) begin
      #1;
      check("idle_rv_fill_valid", fill_valid, 1'b0);
      check("idle_rv_done", {ic_done, dc_done}, 2'b00);
      check("idle_rv_busy", busy, 1'b0);
      @(negedge clk);
    end
    inject_rv = 1'b0;
    idle(1);

    // Random mix of stores and fills, biased toward block 0x0040
    for (int i = 0; i < 10; i++) begin
      int          op;
      logic [15:0] a;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = {12'h004, 3'($urandom_range(0, 7)), 1'b0};
        do_write(a, 16'($urandom));
      end else begin
        a = (op == 1) ? 16'($urandom) : {12'h004, 4'($urandom)};
        do_fill(1'($urandom_range(0, 1)), a, "rnd");
      end
      idle($urandom_range(1, 3));
    end

    // Reset in FILL cycle 5
    ic_addr = 16'($urandom);
    ic_req  = 1'b1;
    seen = 0; t = 0;
    while (seen < 6 && t < 30) begin
      @(negedge clk);
      t++;
      if (mem_en) seen++;
    end
    check("mrst_reach", seen, 6);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 1'b0);
    check("mrst_mem_en", mem_en, 1'b0);
    check("mrst_fill_valid", fill_valid, 1'b0);
    check("mrst_done", {ic_done, dc_done}, 2'b00);
    rst = 1'b0; ic_req = 1'b0;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_rvalid) rv++;
      check("mrst_drop_fill", fill_valid, 1'b0);
      check("mrst_drop_done", {ic_done, dc_done}, 2'b00);
      check("mrst_drop_busy", busy, 1'b0);
    end
    check("mrst_returns_seen", (rv > 0), 1'b1);

    // Clean fill after the abandoned one
    do_fill(1'b1, 16'($urandom), "post_rst");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
